// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - mode encodings and decode helpers for the universal shift register
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_SHR   = 3'd1;
  localparam logic [2:0] MODE_SHL   = 3'd2;
  localparam logic [2:0] MODE_ASR   = 3'd3;
  localparam logic [2:0] MODE_ROR   = 3'd4;
  localparam logic [2:0] MODE_ROL   = 3'd5;
  localparam logic [2:0] MODE_LOAD  = 3'd6;
  localparam logic [2:0] MODE_CLEAR = 3'd7;

  // Only the two serial-input shifts accept a new bit into the word.
  function automatic logic is_serial_mode(input logic [2:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL);
  endfunction

  function automatic logic is_restart_mode(input logic [2:0] mode);
    return (mode == MODE_LOAD) || (mode == MODE_CLEAR);
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// rtl/shift_bit_counter.sv - counts serial bits into the current word and pulses word_valid on completion
module shift_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  input  logic             restart,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_valid
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             word_valid_d, word_valid_q;

  // The counter wraps on the final bit instead of showing WIDTH.
  always_comb begin
    cnt_d        = cnt_q;
    word_valid_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == LAST_BIT) begin
        cnt_d        = '0;
        word_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q        <= '0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign bit_cnt    = cnt_q;
  assign word_valid = word_valid_q;

endmodule

// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - universal shift register with shift/rotate/load/clear and word framing
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data_out,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_valid
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             cnt_inc;
  logic             cnt_restart;

  always_comb begin
    data_d = data_q;
    if (en) begin
      case (mode)
        MODE_HOLD:  data_d = data_q;
        MODE_SHR:   data_d = {sin_l, data_q[WIDTH-1:1]};
        MODE_SHL:   data_d = {data_q[WIDTH-2:0], sin_r};
        MODE_ASR:   data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        MODE_ROR:   data_d = {data_q[0], data_q[WIDTH-1:1]};
        MODE_ROL:   data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        MODE_LOAD:  data_d = load_data;
        MODE_CLEAR: data_d = '0;
        default:    data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign cnt_inc     = en && is_serial_mode(mode);
  assign cnt_restart = en && is_restart_mode(mode);

  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk        (clk),
    .clr_n      (clr_n),
    .inc        (cnt_inc),
    .restart    (cnt_restart),
    .bit_cnt    (bit_cnt),
    .word_valid (word_valid)
  );

  // Serial outputs tap the register directly so they never see input glitches.
  assign data_out = data_q;
  assign sout_r   = data_q[0];
  assign sout_l   = data_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb/tb_shift_reg_univ.sv - scoreboard bench for shift_reg_univ against a behavioural model
module tb_shift_reg_univ;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic          sin_l = 1'b0;
  logic          sin_r = 1'b0;
  logic [W-1:0]  load_data = '0;
  logic [W-1:0]  data_out;
  logic          sout_r;
  logic          sout_l;
  logic [CW-1:0] bit_cnt;
  logic          word_valid;

  shift_reg_univ #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .en         (en),
    .mode       (mode),
    .sin_l      (sin_l),
    .sin_r      (sin_r),
    .load_data  (load_data),
    .data_out   (data_out),
    .sout_r     (sout_r),
    .sout_l     (sout_l),
    .bit_cnt    (bit_cnt),
    .word_valid (word_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           cnt;
    logic         wv;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference state: the word, how many serial bits have arrived, last-cycle completion.
  logic [W-1:0] m_data = '0;
  int           m_cnt = 0;
  logic         m_wv = 1'b0;
  int           wv_pulses;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", nm, act, req);
  endtask

  task automatic model_reset();
    m_data = '0;
    m_cnt  = 0;
    m_wv   = 1'b0;
  endtask

  // Called at a negedge: drives one cycle, predicts the result, returns at the next negedge.
  task automatic op(input logic e, input logic [2:0] md, input logic sl,
                    input logic sr, input logic [W-1:0] ld);
    bit   shifted;
    exp_t x;
    en = e; mode = md; sin_l = sl; sin_r = sr; load_data = ld;
    shifted = 0;
    if (e) begin
      case (md)
        3'd1: begin m_data = (m_data >> 1) | (W'(sl) << (W - 1)); shifted = 1; end
        3'd2: begin m_data = (m_data << 1) | W'(sr); shifted = 1; end
        3'd3: m_data = W'($signed(m_data) >>> 1);
        3'd4: m_data = (m_data >> 1) | (m_data << (W - 1));
        3'd5: m_data = (m_data << 1) | (m_data >> (W - 1));
        3'd6: begin m_data = ld; m_cnt = 0; end
        3'd7: begin m_data = '0; m_cnt = 0; end
        default: ;
      endcase
    end
    m_wv = 1'b0;
    if (shifted) begin
      m_cnt++;
      if (m_cnt == W) begin
        m_cnt = 0;
        m_wv  = 1'b1;
      end
    end
    x.data = m_data; x.cnt = m_cnt; x.wv = m_wv;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("data_out", 64'(data_out), 64'(mon_e.data));
      chk("bit_cnt", 64'(bit_cnt), 64'(mon_e.cnt));
      chk("word_valid", 64'(word_valid), 64'(mon_e.wv));
      chk("sout_r", 64'(sout_r), 64'(mon_e.data[0]));
      chk("sout_l", 64'(sout_l), 64'(mon_e.data[W-1]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ser_bits;
    ser_bits = 8'b0100_1101;

    @(negedge clk);
    chk("reset_data", 64'(data_out), 64'h0);
    chk("reset_cnt", 64'(bit_cnt), 64'h0);
    chk("reset_wv", 64'(word_valid), 64'h0);

    // Edge while clr_n still low must ignore en/mode.
    en = 1'b1; mode = 3'd6; load_data = 8'hFF;
    @(negedge clk);
    chk("reset_ignores_load", 64'(data_out), 64'h0);
    clr_n = 1'b1; en = 1'b0;
    @(negedge clk);

    // Partial word, then load A5 and reset asynchronously between edges.
    for (int i = 0; i < 3; i++) op(1, 3'd1, 1'b1, 1'b0, '0);
    op(1, 3'd6, 0, 0, 8'hA5);
    op(1, 3'd1, 1'b0, 1'b0, '0);
    op(1, 3'd6, 0, 0, 8'hA5);
    op(1, 3'd1, 1'b1, 1'b0, '0);
    en = 1'b0;
    #1 clr_n = 1'b0;
    #1;
    chk("async_clr_data", 64'(data_out), 64'h0);
    chk("async_clr_cnt", 64'(bit_cnt), 64'h0);
    chk("async_clr_wv", 64'(word_valid), 64'h0);
    clr_n = 1'b1;
    model_reset();
    @(negedge clk);

    // Serial-in word: sin_l 1,0,1,1,0,0,1,0 via SHR.
    for (int i = 0; i < 8; i++) begin
      op(1, 3'd1, ser_bits[i], 1'b0, '0);
      if (i < 7) chk("ser_no_early_wv", 64'(word_valid), 64'h0);
    end
    chk("ser_data", 64'(data_out), 64'h4D);
    chk("ser_wv", 64'(word_valid), 64'h1);
    chk("ser_cnt", 64'(bit_cnt), 64'h0);
    op(1, 3'd0, 0, 0, '0);
    chk("ser_wv_one_cycle", 64'(word_valid), 64'h0);

    // Load then rotate.
    op(1, 3'd6, 0, 0, 8'h81);
    op(1, 3'd5, 0, 0, '0);
    chk("rol_data", 64'(data_out), 64'h03);
    op(1, 3'd4, 0, 0, '0);
    op(1, 3'd4, 0, 0, '0);
    chk("ror_data", 64'(data_out), 64'hC0);
    chk("rot_cnt", 64'(bit_cnt), 64'h0);

    // Arithmetic shift right.
    op(1, 3'd6, 0, 0, 8'h90);
    op(1, 3'd3, 0, 0, '0);
    op(1, 3'd3, 0, 0, '0);
    chk("asr_data", 64'(data_out), 64'hE4);
    chk("asr_sout_r", 64'(sout_r), 64'h0);
    chk("asr_sout_l", 64'(sout_l), 64'h1);

    // Mid-word abort by LOAD, then a full word of SHL.
    for (int i = 0; i < 5; i++) op(1, 3'd2, 1'b0, 1'($urandom), '0);
    op(1, 3'd6, 0, 0, 8'h3C);
    chk("abort_cnt", 64'(bit_cnt), 64'h0);
    chk("abort_wv", 64'(word_valid), 64'h0);
    wv_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      op(1, 3'd2, 1'b0, 1'($urandom), '0);
      if (word_valid) wv_pulses++;
    end
    op(1, 3'd0, 0, 0, '0);
    if (word_valid) wv_pulses++;
    chk("abort_wv_pulses", 64'(wv_pulses), 64'h1);

    // Enable gating with CLEAR on mode.
    for (int i = 0; i < 3; i++) op(1, 3'd1, 1'($urandom), 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      op(0, 3'd7, 0, 0, '0);
      chk("gate_data", 64'(data_out), 64'(m_data));
      chk("gate_cnt", 64'(bit_cnt), 64'h3);
      chk("gate_wv", 64'(word_valid), 64'h0);
    end

    // Randomised traffic, weighted toward serial shifts so words complete.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] md;
      md = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'($urandom_range(1, 2));
      op(1'($urandom_range(0, 3) != 0), md, 1'($urandom), 1'($urandom), 8'($urandom));
    end

    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
